markov_song_gen: RTL

MARKOV_SONG_GEN -- requirements
Module: markov_song_gen

---
 rtl/markov_song_gen.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/markov_song_gen.sv
// -----------------------------------------------------------------------------
// markov_song_gen
//
// Generates a song of SONG_LEN pitches from a first-order Markov chain. Each
// row of the transition-weight table holds the weights from one current pitch
// to every candidate next pitch. For each note a random draw r in
// 0..PROB_TOTAL-1 is taken from a 16-bit Galois LFSR, the weights of the
// current row are accumulated column by column, and the first column whose
// running sum exceeds r becomes the next note. Committed notes are streamed
// out and stored in a song buffer that can be read back at any time.
//
// Ports
//   CLOCK_50    clock, rising edge
//   reset_n     synchronous active-low reset
//   start       one-cycle pulse, begins a new song (ignored while busy)
//   seed_load   loads seed into the LFSR (seed 0 loads 16'hACE1)
//   seed        16-bit LFSR seed
//   tbl_we      weight table write strobe (ignored while busy)
//   tbl_cur     table row (current pitch)
//   tbl_next    table column (candidate next pitch)
//   tbl_wdata   weight to write
//   rd_addr     song buffer read index
//   rd_note     song buffer read data, one cycle after rd_addr
//   note_valid  one-cycle pulse per committed note
//   note_out    committed note, valid with note_valid
//   note_count  notes committed in the current song
//   busy        high while a song is being generated
//   done        high from song completion until the next start or reset
// -----------------------------------------------------------------------------
module markov_song_gen #(
   parameter int NUM_NOTES  = 16,
   parameter int NOTE_W     = 4,
   parameter int SONG_LEN   = 256,
   parameter int PROB_W     = 7,
   parameter int PROB_TOTAL = 100,
   parameter int CNT_W      = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              start,
   input  logic              seed_load,
   input  logic [15:0]       seed,
   input  logic              tbl_we,
   input  logic [NOTE_W-1:0] tbl_cur,
   input  logic [NOTE_W-1:0] tbl_next,
   input  logic [PROB_W-1:0] tbl_wdata,
   input  logic [CNT_W-1:0]  rd_addr,
   output logic [NOTE_W-1:0] rd_note,
   output logic              note_valid,
   output logic [NOTE_W-1:0] note_out,
   output logic [CNT_W:0]    note_count,
   output logic              busy,
   output logic              done
);

   // Accumulator is wide enough to sum a full row of maximum weights.
   localparam int ACC_W   = PROB_W + NOTE_W;
   localparam int TBL_N   = NUM_NOTES * NUM_NOTES;
   localparam int TBL_AW  = (TBL_N > 1) ? $clog2(TBL_N) : 1;
   localparam int SONG_AW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;

   localparam logic [15:0]       LFSR_INIT = 16'hACE1;
   // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
   localparam logic [15:0]       LFSR_TAPS = 16'hB400;
   localparam logic [NOTE_W-1:0] IDX_LAST  = NOTE_W'(NUM_NOTES - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DRAW   = 3'd1,
      S_SCAN   = 3'd2,
      S_COMMIT = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   // One Galois LFSR step.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] shifted;
      shifted = v >> 1;
      if (v[0]) begin
         lfsr_step = shifted ^ LFSR_TAPS;
      end else begin
         lfsr_step = shifted;
      end
   endfunction

   // Scale a 16-bit random value into 0..PROB_TOTAL-1 with a full-width
   // product, so the draw is unbiased up to the LFSR resolution.
   function automatic logic [ACC_W-1:0] draw_scale(input logic [15:0] v);
      logic [31:0] prod;
      prod       = {16'h0000, v} * 32'(PROB_TOTAL);
      draw_scale = ACC_W'(prod >> 16);
   endfunction

   // Flat index of table entry [row][col].
   function automatic logic [TBL_AW-1:0] tbl_index(input logic [NOTE_W-1:0] row,
                                                   input logic [NOTE_W-1:0] col);
      tbl_index = TBL_AW'(32'(row) * 32'(NUM_NOTES) + 32'(col));
   endfunction

   state_t              state_r;
   logic [15:0]         lfsr_r;
   logic [NOTE_W-1:0]   cur_note_r;
   logic [NOTE_W-1:0]   idx_r;
   logic [NOTE_W-1:0]   sel_r;
   logic                found_r;
   logic [ACC_W-1:0]    acc_r;
   logic [ACC_W-1:0]    r_r;

   logic [PROB_W-1:0]   weight_mem [TBL_N];
   logic [NOTE_W-1:0]   song_mem   [SONG_LEN];

   logic                tbl_wr_s;
   logic [TBL_AW-1:0]   tbl_wr_idx_s;
   logic [PROB_W-1:0]   weight_s;
   logic [ACC_W-1:0]    acc_sum_s;
   logic                song_wr_s;
   logic [SONG_AW-1:0]  song_wr_idx_s;
   logic                rd_in_range_s;
   logic [CNT_W:0]      count_inc_s;
   logic                more_notes_s;

   // Table writes are accepted only while idle or done, so the weights a song
   // reads can never change under it; out-of-range coordinates are dropped.
   assign tbl_wr_s      = tbl_we && !busy
                          && (32'(tbl_cur)  < 32'(NUM_NOTES))
                          && (32'(tbl_next) < 32'(NUM_NOTES));
   assign tbl_wr_idx_s  = tbl_index(tbl_cur, tbl_next);

   // Live read of the weight under the scan cursor.
   assign weight_s      = weight_mem[tbl_index(cur_note_r, idx_r)];
   assign acc_sum_s     = acc_r + ACC_W'(weight_s);

   // A commit is suppressed on a reset edge so an abort writes nothing more.
   assign song_wr_s     = reset_n && (state_r == S_COMMIT);
   assign song_wr_idx_s = note_count[SONG_AW-1:0];
   assign rd_in_range_s = (32'(rd_addr) < 32'(SONG_LEN));

   assign count_inc_s   = note_count + {{CNT_W{1'b0}}, 1'b1};
   assign more_notes_s  = (32'(count_inc_s) < 32'(SONG_LEN));

   // Weight table storage; deliberately not cleared by reset.
   always_ff @(posedge CLOCK_50) begin
      if (tbl_wr_s) begin
         weight_mem[tbl_wr_idx_s] <= tbl_wdata;
      end
   end

   // Song buffer storage and its registered read port; not cleared by reset,
   // so unwritten entries keep their previous contents.
   always_ff @(posedge CLOCK_50) begin
      if (song_wr_s) begin
         song_mem[song_wr_idx_s] <= sel_r;
      end
      if (rd_in_range_s) begin
         rd_note <= song_mem[rd_addr[SONG_AW-1:0]];
      end else begin
         rd_note <= {NOTE_W{1'b0}};
      end
   end

   // Random source: free-running LFSR, seed load takes priority over advance.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         lfsr_r <= LFSR_INIT;
      end else if (seed_load) begin
         if (seed == 16'h0000) begin
            lfsr_r <= LFSR_INIT;
         end else begin
            lfsr_r <= seed;
         end
      end else begin
         lfsr_r <= lfsr_step(lfsr_r);
      end
   end

   // Song generation FSM: DRAW (1) + SCAN (NUM_NOTES) + COMMIT (1) per note.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state_r    <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         note_valid <= 1'b0;
         note_out   <= {NOTE_W{1'b0}};
         note_count <= {(CNT_W+1){1'b0}};
         cur_note_r <= {NOTE_W{1'b0}};
         idx_r      <= {NOTE_W{1'b0}};
         sel_r      <= {NOTE_W{1'b0}};
         found_r    <= 1'b0;
         acc_r      <= {ACC_W{1'b0}};
         r_r        <= {ACC_W{1'b0}};
      end else begin
         note_valid <= 1'b0;
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_r    <= S_DRAW;
                  cur_note_r <= {NOTE_W{1'b0}};
                  note_count <= {(CNT_W+1){1'b0}};
                  busy       <= 1'b1;
                  done       <= 1'b0;
               end else begin
                  state_r    <= state_r;
               end
            end
            S_DRAW: begin
               r_r     <= draw_scale(lfsr_r);
               idx_r   <= {NOTE_W{1'b0}};
               acc_r   <= {ACC_W{1'b0}};
               sel_r   <= {NOTE_W{1'b0}};
               found_r <= 1'b0;
               state_r <= S_SCAN;
            end
            S_SCAN: begin
               acc_r <= acc_sum_s;
               // sel stays 0 (REST) if the row never exceeds the draw.
               if (!found_r && (acc_sum_s > r_r)) begin
                  sel_r   <= idx_r;
                  found_r <= 1'b1;
               end else begin
                  found_r <= found_r;
               end
               if (idx_r == IDX_LAST) begin
                  state_r <= S_COMMIT;
               end else begin
                  idx_r   <= idx_r + {{(NOTE_W-1){1'b0}}, 1'b1};
               end
            end
            S_COMMIT: begin
               note_out   <= sel_r;
               note_valid <= 1'b1;
               cur_note_r <= sel_r;
               note_count <= count_inc_s;
               if (more_notes_s) begin
                  state_r <= S_DRAW;
               end else begin
                  state_r <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
